// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I shared constants, ID/EX bundle type and decode helpers
package riscv_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;
  localparam logic [3:0] ALU_LUI = 4'd10;
  localparam logic [3:0] ALU_BEQ = 4'd11;
  localparam logic [3:0] ALU_BNE = 4'd12;
  localparam logic [3:0] ALU_BGE = 4'd13;
  localparam logic [3:0] ALU_BLT = 4'd14;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] JUMP_NONE = 2'd0;
  localparam logic [1:0] JUMP_JAL  = 2'd1;
  localparam logic [1:0] JUMP_JALR = 2'd2;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic        is_signed;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] store_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic        branch_en;
    logic [1:0]  jump;
    logic        illegal;
  } id_ex_t;

  // Shared funct3 -> ALU op map for OP and OP-IMM (SLT/SLTU both map to SLT).
  function automatic logic [3:0] base_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_imm_gen.sv
// rtl/id_imm_gen.sv - RV32I immediate extraction and format classification
module id_imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_fmt_e    fmt
);

  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                      fmt = FMT_S;
      OPC_BRANCH:                     fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
      OPC_JAL:                        fmt = FMT_J;
      default:                        fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'd0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - RV32I decode stage driving the ID/EX pipeline register
module id_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            stall,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  output logic [3:0]      alu_op,
  output logic            is_signed,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      mem_size,
  output logic            branch_en,
  output logic [1:0]      jump,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_val;
  logic [31:0] shamt;
  imm_fmt_e    imm_fmt;
  logic        shift_imm;
  logic        bad;
  id_ex_t      dec;
  id_ex_t      q;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign shamt    = {27'd0, in_instr[24:20]};

  id_imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm_val),
    .fmt   (imm_fmt)
  );

  // Shift immediates reuse the I-format slot but the upper bits are funct7, not immediate.
  assign shift_imm = (imm_fmt == FMT_I) && (opcode == OPC_OP_IMM) && (funct3[1:0] == 2'b01);

  always_comb begin
    dec        = '0;
    bad        = 1'b0;
    dec.valid  = 1'b1;
    dec.pc     = in_pc;
    dec.alu_op = ALU_ADD;
    dec.rd     = in_instr[11:7];
    dec.imm    = imm_val;
    case (opcode)
      OPC_OP: begin
        dec.alu_a     = rs1_data;
        dec.alu_b     = rs2_data;
        dec.reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          dec.alu_op    = base_alu_op(funct3);
          dec.is_signed = (funct3 == 3'b010);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
        end else if (MUL_EN && funct7 == F7_MULDIV && funct3 == 3'b000) begin
          dec.alu_op = ALU_MUL;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.alu_a     = rs1_data;
        dec.alu_b     = imm_val;
        dec.reg_write = 1'b1;
        if (shift_imm) begin
          dec.alu_b = shamt;
          if (funct7 == F7_BASE) dec.alu_op = base_alu_op(funct3);
          else if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_op = ALU_SRA;
          else bad = 1'b1;
        end else begin
          dec.alu_op    = base_alu_op(funct3);
          dec.is_signed = (funct3 == 3'b010);
        end
      end
      OPC_LOAD: begin
        dec.alu_a     = rs1_data;
        dec.alu_b     = imm_val;
        dec.mem_read  = 1'b1;
        dec.mem_size  = funct3;
        dec.reg_write = 1'b1;
        bad = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
      end
      OPC_STORE: begin
        dec.alu_a      = rs1_data;
        dec.alu_b      = imm_val;
        dec.store_data = rs2_data;
        dec.mem_write  = 1'b1;
        dec.mem_size   = funct3;
        dec.rd         = 5'd0;
        bad = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        dec.alu_a     = rs1_data;
        dec.alu_b     = rs2_data;
        dec.branch_en = 1'b1;
        dec.rd        = 5'd0;
        dec.is_signed = !funct3[1];
        case (funct3)
          3'b000:        dec.alu_op = ALU_BEQ;
          3'b001:        dec.alu_op = ALU_BNE;
          3'b100, 3'b110: dec.alu_op = ALU_BLT;
          3'b101, 3'b111: dec.alu_op = ALU_BGE;
          default:       bad = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU forms the link value; the target comes from imm on the branch path.
        dec.alu_a     = in_pc;
        dec.alu_b     = 32'd4;
        dec.reg_write = 1'b1;
        dec.jump      = (opcode == OPC_JAL) ? JUMP_JAL : JUMP_JALR;
        bad = (opcode == OPC_JALR) && (funct3 != 3'b000);
      end
      OPC_LUI: begin
        dec.alu_op    = ALU_LUI;
        dec.alu_b     = imm_val;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_a     = in_pc;
        dec.alu_b     = imm_val;
        dec.reg_write = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        dec.rd  = 5'd0;
        dec.imm = '0;
      end
      default: bad = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    if (bad) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
      dec.pc      = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) q <= '0;
    else if (!stall)  q <= in_valid ? dec : '0;
  end

  assign out_valid  = q.valid;
  assign alu_op     = q.alu_op;
  assign is_signed  = q.is_signed;
  assign alu_a      = q.alu_a;
  assign alu_b      = q.alu_b;
  assign store_data = q.store_data;
  assign imm        = q.imm;
  assign pc_out     = q.pc;
  assign rd         = q.rd;
  assign reg_write  = q.reg_write;
  assign mem_read   = q.mem_read;
  assign mem_write  = q.mem_write;
  assign mem_size   = q.mem_size;
  assign branch_en  = q.branch_en;
  assign jump       = q.jump;
  assign illegal    = q.illegal;

endmodule
